// File: rtl/tile_cfg_bank_sequencer_if.sv
// Bitstream word stream between a configuration source and the bank sequencer.
interface tile_cfg_bank_sequencer_if #(
    parameter int unsigned WORD_W = 32
) ();

    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    // Source side: offers words, observes backpressure.
    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready
    );

    // Sequencer side: consumes words, drives ready.
    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready
    );

endinterface

// File: rtl/tile_cfg_bank_sequencer.sv
// Serial programmer for a tile's configuration cells: walks every address once,
// driving bl/wl through SETUP, PULSE and HOLD phases for each bit of the bitstream.
module tile_cfg_bank_sequencer #(
    parameter int unsigned NUM_BITS = 1260,
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned WL_PULSE = 1,
    parameter int unsigned CNT_W    = 11
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    tile_cfg_bank_sequencer_if.slave   cfg,
    output logic [0:NUM_BITS-1]        bl,
    output logic [0:NUM_BITS-1]        wl,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           bit_count
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_SETUP = 3'd2;
    localparam logic [2:0] ST_PULSE = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam int unsigned KW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned PW = 4;

    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    addr_q, addr_d;
    logic [KW-1:0]       k_q, k_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [CNT_W-1:0]    bit_count_q, bit_count_d;
    logic [0:NUM_BITS-1] bl_q, bl_d;
    logic [0:NUM_BITS-1] wl_q, wl_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cur_bit;

    // Bit of the current word that belongs to the address being entered.
    assign cur_bit = word_d[k_d];

    // Sequencing: state, address/bit index, captured word and pulse timing.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        k_d         = k_q;
        word_d      = word_q;
        pcnt_d      = pcnt_q;
        bit_count_d = bit_count_q;
        if (abort) begin
            // bit_count is deliberately left alone so a debugger can see how far it got.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d     = ST_FETCH;
                        addr_d      = '0;
                        bit_count_d = '0;
                    end
                end
                ST_FETCH: begin
                    if (cfg.cfg_valid && cfg_ready_q) begin
                        word_d  = cfg.cfg_data;
                        k_d     = '0;
                        state_d = ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    pcnt_d  = '0;
                    state_d = ST_PULSE;
                end
                ST_PULSE: begin
                    if (pcnt_q == PW'(WL_PULSE - 1)) begin
                        state_d = ST_HOLD;
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    bit_count_d = bit_count_q + 1'b1;
                    addr_d      = addr_q + 1'b1;
                    k_d         = k_q + 1'b1;
                    // Last address wins over end-of-word: trailing word bits are dropped.
                    if (addr_q == CNT_W'(NUM_BITS - 1)) begin
                        state_d = ST_DONE;
                    end else if (k_q == KW'(WORD_W - 1)) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Registered outputs derived from the state being entered.
    always_comb begin
        bl_d        = '0;
        wl_d        = '0;
        cfg_ready_d = (state_d == ST_FETCH);
        busy_d      = (state_d == ST_FETCH) || (state_d == ST_SETUP) ||
                      (state_d == ST_PULSE) || (state_d == ST_HOLD);
        done_d      = (state_d == ST_DONE);
        case (state_d)
            ST_SETUP: begin
                // bl only ever changes here; PULSE and HOLD hold it.
                for (int unsigned i = 0; i < NUM_BITS; i++) begin
                    bl_d[i] = cur_bit && (addr_d == CNT_W'(i));
                end
            end
            ST_PULSE: begin
                bl_d = bl_q;
                for (int unsigned i = 0; i < NUM_BITS; i++) begin
                    wl_d[i] = (addr_d == CNT_W'(i));
                end
            end
            ST_HOLD: bl_d = bl_q;
            default: ;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            k_q         <= '0;
            word_q      <= '0;
            pcnt_q      <= '0;
            bit_count_q <= '0;
            bl_q        <= '0;
            wl_q        <= '0;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            k_q         <= k_d;
            word_q      <= word_d;
            pcnt_q      <= pcnt_d;
            bit_count_q <= bit_count_d;
            bl_q        <= bl_d;
            wl_q        <= wl_d;
            cfg_ready_q <= cfg_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cfg.cfg_ready = cfg_ready_q;
    assign bl            = bl_q;
    assign wl            = wl_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign bit_count     = bit_count_q;

endmodule

// File: tb/tb_tile_cfg_bank_sequencer.sv
// Self-checking bench for tile_cfg_bank_sequencer: default, long-pulse and short-bank instances.
module tb_tile_cfg_bank_sequencer;

    localparam int NA = 1260;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: default sizing.
    logic            start_a, abort_a, busy_a, done_a;
    logic [0:NA-1]   bl_a, wl_a;
    logic [10:0]     bc_a;
    tile_cfg_bank_sequencer_if #(.WORD_W(32)) if_a ();

    tile_cfg_bank_sequencer dut_a (
        .clk       (clk),
        .reset     (reset),
        .start     (start_a),
        .abort     (abort_a),
        .cfg       (if_a),
        .bl        (bl_a),
        .wl        (wl_a),
        .busy      (busy_a),
        .done      (done_a),
        .bit_count (bc_a)
    );

    // Instance B: 8 cells, 4-cycle word-line pulse.
    logic            start_b, abort_b, busy_b, done_b;
    logic [0:7]      bl_b, wl_b;
    logic [3:0]      bc_b;
    tile_cfg_bank_sequencer_if #(.WORD_W(32)) if_b ();

    tile_cfg_bank_sequencer #(
        .NUM_BITS (8),
        .WORD_W   (32),
        .WL_PULSE (4),
        .CNT_W    (4)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .start     (start_b),
        .abort     (abort_b),
        .cfg       (if_b),
        .bl        (bl_b),
        .wl        (wl_b),
        .busy      (busy_b),
        .done      (done_b),
        .bit_count (bc_b)
    );

    // Instance C: 40 cells, final word partially used.
    logic            start_c, abort_c, busy_c, done_c;
    logic [0:39]     bl_c, wl_c;
    logic [5:0]      bc_c;
    tile_cfg_bank_sequencer_if #(.WORD_W(32)) if_c ();

    tile_cfg_bank_sequencer #(
        .NUM_BITS (40),
        .WORD_W   (32),
        .WL_PULSE (1),
        .CNT_W    (6)
    ) dut_c (
        .clk       (clk),
        .reset     (reset),
        .start     (start_c),
        .abort     (abort_c),
        .cfg       (if_c),
        .bl        (bl_c),
        .wl        (wl_c),
        .busy      (busy_c),
        .done      (done_c),
        .bit_count (bc_c)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    typedef struct {
        int   addr;
        logic b;
    } sb_t;
    sb_t sb_q[$];
    int  sb_addr;

    logic [0:NA-1] wl_prev, bl_prev;
    int onehot_viol, blchg_viol, pulses_a;

    typedef struct {
        logic       rst;
        logic       st;
        logic       ab;
        logic       vld;
        logic [4:0] exp; // {cfg_ready, busy, done, bl/wl quiet, bit_count zero}
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One clock; samples 1 ns after the edge and runs the instance-A monitor/scoreboard.
    task automatic tick();
        int  idx;
        sb_t e;
        @(posedge clk);
        #1;
        cyc++;
        if ($countones(wl_a) > 1) onehot_viol++;
        if (wl_a != '0 && bl_a != bl_prev) blchg_viol++;
        if (wl_a != '0 && wl_prev == '0) begin
            idx = -1;
            for (int i = 0; i < NA; i++) if (wl_a[i]) idx = i;
            pulses_a++;
            if (sb_q.size() == 0) begin
                check("sb_entry_at_pulse", 0, 1);
            end else begin
                e = sb_q.pop_front();
                check("sb_addr", idx, e.addr);
                check("sb_bl_bit", bl_a[idx], e.b);
                check("sb_bl_ones", $countones(bl_a), e.b);
            end
        end
        wl_prev = wl_a;
        bl_prev = bl_a;
    endtask

    task automatic prog_start_a();
        sb_q.delete();
        sb_addr  = 0;
        pulses_a = 0;
        start_a  = 1'b1;
        tick();
        start_a  = 1'b0;
    endtask

    // Presents nwords words; at word gap_at valid is withheld for 10 cycles in FETCH.
    task automatic feed_a(input int nwords, input int gap_at, input bit rnd);
        int  t;
        int  gap_bad;
        sb_t e;
        for (int i = 0; i < nwords; i++) begin
            if (i == gap_at) begin
                if_a.cfg_valid = 1'b0;
                t = 0;
                while (!if_a.cfg_ready && t < 200) begin tick(); t++; end
                check("gap_fetch_reached", if_a.cfg_ready, 1);
                gap_bad = 0;
                repeat (10) begin
                    tick();
                    if (!if_a.cfg_ready || bl_a != '0 || wl_a != '0) gap_bad++;
                end
                check("gap_quiet", gap_bad, 0);
            end
            if_a.cfg_data  = rnd ? $urandom() : 32'hA5A5A5A5;
            if_a.cfg_valid = 1'b1;
            t = 0;
            while (!if_a.cfg_ready && t < 200) begin tick(); t++; end
            if (!if_a.cfg_ready) begin
                check("fetch_timeout", 0, 1);
                return;
            end
            for (int j = 0; j < 32; j++) begin
                if (sb_addr < NA) begin
                    e.addr = sb_addr;
                    e.b    = if_a.cfg_data[j];
                    sb_q.push_back(e);
                    sb_addr++;
                end
            end
            tick();
        end
    endtask

    task automatic wait_done_a(input int max_cyc, input string name);
        int t = 0;
        while (!done_a && t < max_cyc) begin tick(); t++; end
        check(name, done_a, 1);
    endtask

    initial begin
        int          t0, t, cnt, idx, nw, pulses_c, order_bad;
        logic [0:7]  ewl, ebl;
        logic        edone, rdy, eb;
        logic [31:0] w0, w1;
        logic [0:39] wlc_prev;

        reset   = 1'b1;
        start_a = 1'b0; abort_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0;
        start_c = 1'b0; abort_c = 1'b0;
        if_a.cfg_valid = 1'b0; if_a.cfg_data = '0;
        if_b.cfg_valid = 1'b0; if_b.cfg_data = '0;
        if_c.cfg_valid = 1'b0; if_c.cfg_data = '0;
        wl_prev = '0; bl_prev = '0;
        onehot_viol = 0; blchg_viol = 0; pulses_a = 0;

        // Test 1: reset, idle, control priorities (table-driven).
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b00011};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'b00011};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b00011};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b00011};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'b00011};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b11011};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b11011};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b11011};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b00011};
        for (int i = 0; i < 9; i++) begin
            reset          = vecs[i].rst;
            start_a        = vecs[i].st;
            abort_a        = vecs[i].ab;
            if_a.cfg_valid = vecs[i].vld;
            tick();
            check($sformatf("vec%0d", i),
                  {if_a.cfg_ready, busy_a, done_a, (bl_a == '0 && wl_a == '0), (bc_a == '0)},
                  vecs[i].exp);
        end
        reset = 1'b0; start_a = 1'b0; abort_a = 1'b0; if_a.cfg_valid = 1'b0;
        tick();

        // Test 2: full default program, valid held high.
        onehot_viol = 0; blchg_viol = 0;
        prog_start_a();
        t0 = cyc;
        feed_a(40, -1, 1'b0);
        wait_done_a(5000, "t2_done_timeout");
        check("t2_done_latency", cyc - t0, 1260 * 3 + 40);
        check("t2_bit_count", bc_a, 1260);
        check("t2_pulses", pulses_a, 1260);
        check("t2_sb_drained", sb_q.size(), 0);
        cnt = 0;
        repeat (5) begin tick(); if (if_a.cfg_ready) cnt++; end
        check("t2_ready_after_done", cnt, 0);
        check("t2_done_sticky", done_a, 1);
        check("t2_wl_onehot", onehot_viol, 0);
        check("t2_bl_stable_in_pulse", blchg_viol, 0);
        if_a.cfg_valid = 1'b0;

        // Test 4: starvation in FETCH, random bitstream.
        prog_start_a();
        feed_a(40, 1, 1'b1);
        wait_done_a(5000, "t4_done_timeout");
        check("t4_bit_count", bc_a, 1260);
        check("t4_pulses", pulses_a, 1260);
        check("t4_sb_drained", sb_q.size(), 0);
        if_a.cfg_valid = 1'b0;

        // Test 5: abort during the pulse of address 37, then reprogram.
        prog_start_a();
        feed_a(2, -1, 1'b1);
        if_a.cfg_valid = 1'b0;
        t = 0;
        while (!wl_a[37] && t < 200) begin tick(); t++; end
        check("t5_reached_addr37", wl_a[37], 1);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("t5_busy", busy_a, 0);
        check("t5_wl_quiet", (wl_a == '0), 1);
        check("t5_bl_quiet", (bl_a == '0), 1);
        check("t5_done", done_a, 0);
        check("t5_ready", if_a.cfg_ready, 0);
        check("t5_bit_count", bc_a, 37);
        prog_start_a();
        check("t5_count_cleared", bc_a, 0);
        feed_a(40, -1, 1'b1);
        wait_done_a(5000, "t5_done_timeout");
        check("t5_bit_count_final", bc_a, 1260);
        check("t5_pulses", pulses_a, 1260);
        check("t5_wl_onehot", onehot_viol, 0);
        if_a.cfg_valid = 1'b0;

        // Test 3: WL_PULSE = 4 timeline on 8 cells, word 0x00000001.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        if_b.cfg_data  = 32'h0000_0001;
        if_b.cfg_valid = 1'b1;
        for (int n = 0; n <= 52; n++) begin
            if (n > 0) tick();
            ewl = '0;
            ebl = '0;
            if (n >= 1 && n <= 48) begin
                if ((n - 1) % 6 >= 1 && (n - 1) % 6 <= 4) ewl[(n - 1) / 6] = 1'b1;
                if ((n - 1) / 6 == 0) ebl[0] = 1'b1;
            end
            edone = (n >= 49);
            check($sformatf("t3_cycle%0d", n), {wl_b, bl_b, done_b}, {ewl, ebl, edone});
        end
        check("t3_bit_count", bc_b, 8);
        check("t3_ready_after_done", if_b.cfg_ready, 0);

        // Test 6: 40 cells, final word truncated, post-done behaviour.
        w0 = 32'h3C5A_96E1;
        w1 = 32'hFFFF_FF00;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        if_c.cfg_data  = w0;
        if_c.cfg_valid = 1'b1;
        nw = 0; pulses_c = 0; order_bad = 0; wlc_prev = '0;
        for (int n = 0; n < 300 && !done_c; n++) begin
            rdy = if_c.cfg_ready;
            tick();
            if (rdy) begin
                nw++;
                if_c.cfg_data = (nw == 1) ? w1 : 32'hFFFF_FFFF;
            end
            if (wl_c != '0 && wlc_prev == '0) begin
                idx = -1;
                for (int i = 0; i < 40; i++) if (wl_c[i]) idx = i;
                if (idx != pulses_c || $countones(bl_c) > 1) order_bad++;
                pulses_c++;
                if (idx >= 0) begin
                    eb = (idx < 32) ? w0[idx] : w1[idx - 32];
                    check($sformatf("t6_bit%0d", idx), bl_c[idx], eb);
                end
            end
            wlc_prev = wl_c;
        end
        check("t6_done", done_c, 1);
        check("t6_handshakes", nw, 2);
        check("t6_pulses", pulses_c, 40);
        check("t6_order", order_bad, 0);
        check("t6_bit_count", bc_c, 40);
        cnt = 0;
        repeat (5) begin tick(); if (if_c.cfg_ready) cnt++; end
        check("t6_ready_after_done", cnt, 0);
        start_c = 1'b1;
        abort_c = 1'b1;
        tick();
        start_c = 1'b0;
        abort_c = 1'b0;
        check("t6_abort_wins_done", done_c, 0);
        check("t6_abort_wins_busy", busy_c, 0);
        check("t6_bit_count_kept", bc_c, 40);
        if_c.cfg_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/tile_cfg_bank_sequencer.md
Name: tile_cfg_bank_sequencer

Overview:
- Programs a tile's memory-bank configuration cells by driving its flat bl/wl buses, one bit at a time.
- Takes a word-wide bitstream on a valid/ready stream and produces SETUP/PULSE/HOLD phases per address.
- Instantiated once per tile, beside the tile wrapper; its bl/wl outputs connect straight to the tile's bl/wl inputs.
- Default sizing matches a CLB tile (1260 config bits).

Parameters:
- NUM_BITS, 1260: number of configuration cells; bl/wl bus width.
- WORD_W, 32: width of the input bitstream word.
- WL_PULSE, 1: cycles wl stays asserted per bit; legal range 1..15.
- CNT_W, 11: bit-counter width; must satisfy 2^CNT_W > NUM_BITS.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin programming; honoured only in IDLE or DONE.
- abort  input  1  cancels programming; takes effect at the next edge.
- cfg_data  input  WORD_W  bitstream word; bit 0 is programmed first.
- cfg_valid  input  1  cfg_data valid.
- cfg_ready  output  1  sequencer can accept a word.
- bl  output  [0:NUM_BITS-1]  bit-line data bus.
- wl  output  [0:NUM_BITS-1]  word-line select bus; at most one bit high.
- busy  output  1  high in any state other than IDLE and DONE.
- done  output  1  sticky; all NUM_BITS bits have been written.
- bit_count  output  CNT_W  number of bits fully written (HOLD completed).

Behaviour:
- Reset values: all outputs are 0; internal state = IDLE, addr = 0, word register = 0.
- Reset dominates start, abort and the handshake.
- All outputs are registered.

States: IDLE, FETCH, SETUP, PULSE, HOLD, DONE.

Transitions:
- IDLE/DONE + start → FETCH. On entry: addr = 0, bit_count = 0, done = 0.
- FETCH: cfg_ready = 1. On cfg_valid & cfg_ready: capture cfg_data, bit index k = 0, go to SETUP. cfg_ready is 0 in every other state.
- SETUP (1 cycle): bl[addr] = word[k], all other bl = 0, wl = 0. Then → PULSE.
- PULSE (WL_PULSE cycles, counted by an internal pulse counter): wl[addr] = 1, bl held. Then → HOLD.
- HOLD (1 cycle): wl = 0, bl held. At exit: bit_count += 1, addr += 1, k += 1.
- After HOLD:
  - if addr == NUM_BITS → DONE;
  - else if k == WORD_W → FETCH;
  - else → SETUP.
- DONE: bl = 0, wl = 0, done = 1 until the next start or reset.

Rules:
- Per-bit cost = WL_PULSE + 2 cycles.
- Word count = ceil(NUM_BITS / WORD_W); default 40 words, with 12 bits used from the last word.
- Unused upper bits of the final word are ignored; the final word is consumed on a single handshake.
- Words presented after DONE are not accepted (cfg_ready = 0); they are not an error.
- wl is one-hot or zero at every cycle; it is never high in SETUP or HOLD.
- bl changes only on the SETUP entry edge.
- No wrap-around: addr never exceeds NUM_BITS; the counters saturate at the DONE transition.
- start while busy is ignored.
- abort (any state, not reset):
  - next edge → IDLE;
  - bl = 0, wl = 0, cfg_ready = 0, done = 0;
  - bit_count retains its value for debug.
- start and abort in the same cycle: abort wins.
- cfg_valid dropping in FETCH: the sequencer waits indefinitely with outputs quiet (bl = 0 and wl = 0, cleared on FETCH entry).
- Upstream may hold cfg_data/cfg_valid while cfg_ready = 0; no data is lost.

Test Plan:
1. Reset then idle: reset for 2 cycles → all outputs 0; cfg_valid = 1 without start → cfg_ready stays 0, bl/wl stay 0.
2. Full program, default parameters: start, then 40 words of 0xA5A5A5A5 with valid held high.
   - done rises 1260 × 3 + 40 FETCH cycles after start acceptance; bit_count = 1260.
   - bl[0] = 1, bl[1] = 0 during their pulses.
   - wl is never multi-hot, checked every cycle.
3. Pulse width: WL_PULSE = 4, single word 0x00000001 with NUM_BITS = 8.
   - wl[0] high exactly 4 cycles with bl[0] = 1, one SETUP cycle before and one HOLD cycle after.
   - Total time to done = 8 × 6 + 1 FETCH cycle.
4. Backpressure/starvation: cfg_valid withheld 10 cycles in FETCH.
   - cfg_ready high throughout; bl/wl 0; resumes on valid with no bit skipped (scoreboard bl vs bitstream per addr).
5. Abort mid-PULSE at addr = 37 → next cycle IDLE, wl = 0, bl = 0, done = 0, bit_count = 37. A new start then reprograms from addr 0.
6. Final-word truncation and post-done: NUM_BITS = 40, WORD_W = 32, second word 0xFFFFFF00.
   - Bits 32..39 written as 0; bits 8..31 of that word are ignored.
   - done = 1; cfg_ready stays 0 with cfg_valid held; start with abort in the same cycle → IDLE, done cleared.
